// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM requester and its bench.
package gcd_lcm_pkg;

    // Sequencer states: idle, core held in reset, one settle cycle, waiting on core, response held
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTART = 3'd1,
        SETTLE  = 3'd2,
        WAIT    = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic OP_GCD = 1'b0;
    localparam logic OP_LCM = 1'b1;

    localparam int DEF_W = 8;

endpackage

// File: rtl/gcd_lcm_requester.sv
// Sequencer for the combined GCD/LCM core: accepts one request, restarts the
// core, waits for ready under a timeout, and holds the response until taken.
module gcd_lcm_requester
    import gcd_lcm_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 600
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_op,
    output logic         rsp_err,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_b,
    output logic         core_prompt,
    output logic         core_reset,
    input  logic         core_ready,
    input  logic [W-1:0] core_result,
    output logic         busy
);

    localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX   = {TW{1'b1}};

    state_t         state_q, state_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [W-1:0]   a_d, b_d, res_d;
    logic           op_d, err_d;

    // The latched op is the response op; it only changes on acceptance
    assign rsp_op = core_prompt;

    // State, counters, latched operands and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            core_a      <= '0;
            core_b      <= '0;
            core_prompt <= 1'b0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            core_a      <= a_d;
            core_b      <= b_d;
            core_prompt <= op_d;
            rsp_result  <= res_d;
            rsp_err     <= err_d;
        end
    end

    // Next-state, next register values and handshake/core control outputs
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        to_cnt_d   = to_cnt_q;
        a_d        = core_a;
        b_d        = core_b;
        op_d       = core_prompt;
        res_d      = rsp_result;
        err_d      = rsp_err;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        core_reset = 1'b1;
        busy       = 1'b1;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    a_d       = req_a;
                    b_d       = req_b;
                    op_d      = req_op;
                    rst_cnt_d = '0;
                    to_cnt_d  = '0;
                    // A zero operand is answered directly; the core is never started
                    if (req_a == '0 || req_b == '0) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = RESTART;
                    end
                end
            end

            RESTART: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end

            // Ready may still be high from the previous operation, so it is ignored here
            SETTLE: begin
                core_reset = 1'b0;
                to_cnt_d   = '0;
                state_d    = WAIT;
            end

            // core_ready takes priority over a timeout landing in the same cycle
            WAIT: begin
                core_reset = 1'b0;
                if (to_cnt_q != TO_MAX)
                    to_cnt_d = to_cnt_q + TW'(1);
                if (core_ready) begin
                    res_d   = core_result;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else if (to_cnt_q >= TO_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_lcm_requester.sv
// Directed bench for gcd_lcm_requester with a behavioural core model and a
// response scoreboard.
module tb_gcd_lcm_requester;
    import gcd_lcm_pkg::*;

    localparam int W  = 8;
    localparam int RC = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_op;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid, rsp_ready, rsp_op, rsp_err;
    logic [W-1:0] rsp_result;
    logic [W-1:0] core_a, core_b, core_result;
    logic         core_prompt, core_reset, core_ready, busy;

    typedef struct {
        logic [W-1:0] res;
        logic         op;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gcd_lcm_requester #(.W(W), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .core_a(core_a), .core_b(core_b), .core_prompt(core_prompt),
        .core_reset(core_reset), .core_ready(core_ready),
        .core_result(core_result), .busy(busy)
    );

    // Behavioural core: answers 4 cycles after reset release unless told to hang;
    // optionally shows a stale ready in the first cycle after reset release
    logic         model_hang  = 1'b0;
    logic         model_stale = 1'b0;
    int           mcnt;
    logic         m_ready;
    logic [W-1:0] m_res;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, t;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    function automatic logic [W-1:0] ref_lcm(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = (int'(a) * int'(b)) / int'(ref_gcd(a, b));
        return W'(p);
    endfunction

    always @(posedge clk) begin
        if (core_reset) begin
            mcnt    <= 0;
            m_ready <= 1'b0;
            m_res   <= '0;
        end else begin
            if (mcnt < 1000)
                mcnt <= mcnt + 1;
            if (!model_hang && mcnt == 4) begin
                m_ready <= 1'b1;
                m_res   <= core_prompt ? ref_lcm(core_a, core_b) : ref_gcd(core_a, core_b);
            end
        end
    end

    assign core_ready  = m_ready | (model_stale && !core_reset && mcnt == 0);
    assign core_result = m_res;

    // Count falling edges of core_reset to prove the core was never started
    logic cr_prev = 1'b1;
    int   rst_falls = 0;
    always @(posedge clk) begin
        cr_prev <= core_reset;
        if (cr_prev && !core_reset)
            rst_falls <= rst_falls + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one request until accepted; returns at the first negedge after acceptance
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input bit push, input logic [W-1:0] er, input logic ee);
        bit acc;
        exp_t e;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("req_accepted", 32'(acc), 32'd1);
        if (push) begin
            e.res = er;
            e.op  = op;
            e.err = ee;
            sb.push_back(e);
        end
        chk("req_ready_low_after_accept", 32'(req_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait for a response, apply `hold` cycles of backpressure, compare, then handshake
    task automatic get_rsp(input int hold, output int lat);
        bit   seen;
        int   k;
        exp_t e;
        seen = 1'b0;
        k    = 0;
        lat  = -1;
        while (!seen && k < 200) begin
            k++;
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        if (!seen) return;
        lat = k;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("bp_result", 32'(rsp_result), 32'(e.res));
            chk("bp_op", 32'(rsp_op), 32'(e.op));
            chk("bp_err", 32'(rsp_err), 32'(e.err));
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_op", 32'(rsp_op), 32'(e.op));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        chk("post_hs_core_reset", 32'(core_reset), 32'd1);
    endtask

    initial begin
        int lat;
        int falls0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_op", 32'(rsp_op), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_core_a", 32'(core_a), 32'd0);
        chk("rst_core_b", 32'(core_b), 32'd0);
        chk("rst_core_prompt", 32'(core_prompt), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // GCD happy path with core_reset timeline: high 2 cycles after accept, then low
        do_req(8'd20, 8'd12, OP_GCD, 1'b1, 8'd4, 1'b0);
        chk("gcd_core_a", 32'(core_a), 32'd20);
        chk("gcd_core_b", 32'(core_b), 32'd12);
        chk("gcd_rst_c1", 32'(core_reset), 32'd1);
        @(negedge clk);
        chk("gcd_rst_c2", 32'(core_reset), 32'd1);
        @(negedge clk);
        chk("gcd_rst_fall", 32'(core_reset), 32'd0);
        get_rsp(0, lat);

        // LCM then GCD back to back
        do_req(8'd20, 8'd12, OP_LCM, 1'b1, 8'd60, 1'b0);
        chk("lcm_prompt", 32'(core_prompt), 32'd1);
        get_rsp(0, lat);
        do_req(8'd9, 8'd6, OP_GCD, 1'b1, 8'd3, 1'b0);
        get_rsp(0, lat);

        // Zero operand: immediate error response, core never released
        falls0 = rst_falls;
        do_req(8'd0, 8'd7, OP_LCM, 1'b1, 8'd0, 1'b1);
        get_rsp(0, lat);
        chk("zero_latency", 32'(lat), 32'd1);
        chk("zero_core_never_started", 32'(rst_falls), 32'(falls0));

        // Backpressure: 10 cycles of rsp_ready low
        do_req(8'd4, 8'd6, OP_LCM, 1'b1, 8'd12, 1'b0);
        get_rsp(10, lat);

        // Timeout with a stale ready during SETTLE
        model_hang  = 1'b1;
        model_stale = 1'b1;
        do_req(8'd20, 8'd12, OP_GCD, 1'b1, 8'd0, 1'b1);
        get_rsp(0, lat);
        chk("timeout_latency", 32'(lat), 32'd20);
        model_stale = 1'b0;

        // Reset while in WAIT drops the operation
        do_req(8'd20, 8'd12, OP_GCD, 1'b0, 8'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_core_reset", 32'(core_reset), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_core_a", 32'(core_a), 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        model_hang = 1'b0;
        do_req(8'd20, 8'd12, OP_GCD, 1'b1, 8'd4, 1'b0);
        get_rsp(0, lat);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
